// File: rtl/if_fetch_queue_if.sv
// Signal bundle between the fetch queue, the ID stage, the redirect sources and the instruction SRAM.
interface if_fetch_queue_if;
  logic        ds_allowin;
  logic [34:0] br_bus;
  logic        wb_ex;
  logic        wb_ertn;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, wb_ex, wb_ertn, csr_eentry, csr_era,
           inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_wr,
           inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, wb_ex, wb_ertn, csr_eentry, csr_era,
           inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_wr,
           inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Multi-outstanding IF stage with an instruction queue in front of ID and stale-response discard on redirect.
// Optional macro IF_BYPASS_EN: a response into an empty queue drives fs_to_ds_* in the same cycle.
module if_fetch_queue #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'h1C000000
) (
  input logic              clk,
  input logic              reset,
  if_fetch_queue_if.master bus
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned QW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(IBUF_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic          adef_hold;
  logic [31:0]   pc_fifo [2**PW];
  logic [PW-1:0] pwp, prp;
  logic [64:0]   ibuf [2**QW];
  logic [QW-1:0] qwp, qrp;
  logic [CW-1:0] count;

  logic        br_stall, br_cancel, br_taken;
  logic [31:0] br_target, redir_target;
  logic        redir, flush, room, req, hs, resp_keep, adef_push, bypass, push, pop;
  logic [64:0] resp_entry, push_entry;

  assign {br_stall, br_cancel, br_taken, br_target} = bus.br_bus;

  assign redir        = bus.wb_ex | bus.wb_ertn | (br_taken & ~br_stall);
  assign flush        = redir | (br_cancel & ~br_taken);
  assign redir_target = bus.wb_ex ? bus.csr_eentry : (bus.wb_ertn ? bus.csr_era : br_target);

  // Queue slots are reserved at issue so every accepted response has a place to land.
  assign room = (32'(outstanding) + 32'(count)) < IBUF_DEPTH;
  assign req  = ~reset & ~redir & ~adef_hold & (fetch_pc[1:0] == 2'b00)
              & (outstanding < OW'(MAX_OUTSTANDING)) & room;
  assign hs   = req & bus.inst_sram_addr_ok;

  assign resp_keep  = bus.inst_sram_data_ok & (discard == '0) & ~flush;
  assign resp_entry = {1'b0, bus.inst_sram_rdata, pc_fifo[prp]};
  assign adef_push  = ~reset & ~flush & ~adef_hold & (fetch_pc[1:0] != 2'b00)
                    & (outstanding == '0) & (count < CW'(IBUF_DEPTH));

`ifdef IF_BYPASS_EN
  assign bypass = resp_keep & (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push       = (resp_keep & ~(bypass & bus.ds_allowin)) | adef_push;
  assign push_entry = adef_push ? {1'b1, 32'h0, fetch_pc} : resp_entry;
  assign pop        = (count != '0) & bus.ds_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      adef_hold   <= 1'b0;
      pwp         <= '0;
      prp         <= '0;
      qwp         <= '0;
      qrp         <= '0;
      count       <= '0;
    end else begin
      outstanding <= outstanding + OW'(hs) - OW'(bus.inst_sram_data_ok);
      if (hs) pwp <= pwp + PW'(1);
      if (bus.inst_sram_data_ok) prp <= prp + PW'(1);
      // Every request still in flight becomes stale; discard is always a subset of outstanding.
      if (redir) begin
        fetch_pc  <= redir_target;
        discard   <= outstanding - OW'(bus.inst_sram_data_ok);
        adef_hold <= 1'b0;
      end else begin
        if (hs) fetch_pc <= fetch_pc + 32'd4;
        if (bus.inst_sram_data_ok && discard != '0) discard <= discard - OW'(1);
        if (adef_push) adef_hold <= 1'b1;
      end
      if (flush) begin
        qwp   <= '0;
        qrp   <= '0;
        count <= '0;
      end else begin
        if (push) qwp <= qwp + QW'(1);
        if (pop)  qrp <= qrp + QW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays need no reset; validity is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (hs)   pc_fifo[pwp] <= fetch_pc;
    if (push) ibuf[qwp]    <= push_entry;
  end

  assign bus.fs_to_ds_valid  = (count != '0) | bypass;
  assign bus.fs_to_ds_bus    = (count != '0) ? ibuf[qrp] : resp_entry;
  assign bus.inst_sram_req   = req;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = 2'b10;
  assign bus.inst_sram_wstrb = 4'h0;
  assign bus.inst_sram_addr  = fetch_pc;
  assign bus.inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based model of the fetch pipeline.
module tb_if_fetch_queue;
  localparam int          MAXO   = 2;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h1C000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_fetch_queue_if bus();

  if_fetch_queue #(
    .MAX_OUTSTANDING(MAXO),
    .IBUF_DEPTH     (DEPTH),
    .RESET_PC       (RST_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int p_aok, p_dok, p_allow;

  logic [31:0] m_pc;
  logic        m_hold;
  logic [32:0] m_infl [$];
  logic [64:0] m_ibuf [$];
  logic [31:0] env_q [$];
  logic [64:0] got [$];
  logic [31:0] hs_addrs [$];
  logic        last_valid, last_req;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
  endfunction

  function automatic logic [64:0] gotat(input int i);
    return (i < got.size()) ? got[i] : {65{1'b1}};
  endfunction

  function automatic logic [31:0] hsat(input int i);
    return (i < hs_addrs.size()) ? hs_addrs[i] : 32'hFFFFFFFF;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.ds_allowin        = $urandom_range(99) < p_allow;
    bus.inst_sram_addr_ok = $urandom_range(99) < p_aok;
    bus.inst_sram_data_ok = (env_q.size() != 0) && ($urandom_range(99) < p_dok);
    bus.inst_sram_rdata   = bus.inst_sram_data_ok ? mem(env_q[0]) : $urandom;
    bus.br_bus            = {3'b000, $urandom};
    bus.wb_ex             = 1'b0;
    bus.wb_ertn           = 1'b0;
    bus.csr_eentry        = $urandom;
    bus.csr_era           = $urandom;
  endtask

  // Checks the DUT outputs for the current inputs, then advances the model by one clock.
  task automatic step();
    logic        stall, cancel, taken, redir, flush, e_req, keep, bypass, adef, e_valid, dut_hs;
    logic [31:0] tgt, tmp;
    logic [32:0] head;
    logic [64:0] entry, e_bus;
    #1;
    {stall, cancel, taken, tgt} = bus.br_bus;
    redir = bus.wb_ex | bus.wb_ertn | (taken & ~stall);
    flush = redir | (cancel & ~taken);
    e_req = !redir && !m_hold && m_pc[1:0] == 2'b00 && m_infl.size() < MAXO
            && (m_infl.size() + m_ibuf.size()) < DEPTH;
    keep  = 1'b0;
    entry = '0;
    if (bus.inst_sram_data_ok && m_infl.size() != 0) begin
      head  = m_infl[0];
      keep  = !head[32] && !flush;
      entry = {1'b0, mem(head[31:0]), head[31:0]};
    end
    bypass = 1'b0;
`ifdef IF_BYPASS_EN
    bypass = keep && m_ibuf.size() == 0;
`endif
    adef    = !flush && !m_hold && m_pc[1:0] != 2'b00 && m_infl.size() == 0 && m_ibuf.size() < DEPTH;
    e_valid = m_ibuf.size() != 0 || bypass;
    e_bus   = (m_ibuf.size() != 0) ? m_ibuf[0] : entry;

    check("req", 65'(bus.inst_sram_req), 65'(e_req));
    if (e_req) check("addr", 65'(bus.inst_sram_addr), 65'(m_pc));
    check("valid", 65'(bus.fs_to_ds_valid), 65'(e_valid));
    if (e_valid) check("bus", bus.fs_to_ds_bus, e_bus);
    check("const", 65'({bus.inst_sram_wr, bus.inst_sram_size, bus.inst_sram_wstrb, bus.inst_sram_wdata}),
          65'({1'b0, 2'b10, 4'h0, 32'h0}));

    last_valid = bus.fs_to_ds_valid;
    last_req   = bus.inst_sram_req;
    if (bus.fs_to_ds_valid && bus.ds_allowin) got.push_back(bus.fs_to_ds_bus);
    dut_hs = bus.inst_sram_req && bus.inst_sram_addr_ok;
    if (dut_hs) hs_addrs.push_back(bus.inst_sram_addr);
    if (bus.inst_sram_data_ok && env_q.size() != 0) tmp = env_q.pop_front();
    if (dut_hs) env_q.push_back(bus.inst_sram_addr);

    if (bus.inst_sram_data_ok && m_infl.size() != 0) head = m_infl.pop_front();
    if (m_ibuf.size() != 0 && bus.ds_allowin) e_bus = m_ibuf.pop_front();
    if (flush) m_ibuf.delete();
    else begin
      if (keep && !(bypass && bus.ds_allowin)) m_ibuf.push_back(entry);
      if (adef) begin
        m_ibuf.push_back({1'b1, 32'h0, m_pc});
        m_hold = 1'b1;
      end
    end
    if (e_req && bus.inst_sram_addr_ok) begin
      m_infl.push_back({1'b0, m_pc});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      foreach (m_infl[i]) m_infl[i][32] = 1'b1;
      m_pc   = bus.wb_ex ? bus.csr_eentry : (bus.wb_ertn ? bus.csr_era : tgt);
      m_hold = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    step();
  endtask

  task automatic redirect(input logic ex, input logic ertn, input logic taken, input logic stall,
                          input logic cancel, input logic [31:0] tgt, input logic [31:0] ee,
                          input logic [31:0] era);
    @(negedge clk);
    drive();
    bus.br_bus     = {stall, cancel, taken, tgt};
    bus.wb_ex      = ex;
    bus.wb_ertn    = ertn;
    bus.csr_eentry = ee;
    bus.csr_era    = era;
    step();
  endtask

  task automatic quiesce();
    p_aok = 0; p_dok = 100; p_allow = 100;
    repeat (8) cycle();
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = 32'h1C000000 | (32'($urandom_range(0, 1023)) << 2);
    if ($urandom_range(9) == 0) t = t + 32'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    p_aok = 100; p_dok = 100; p_allow = 100;
    reset = 1'b1;
    drive();
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rst_req", 65'(bus.inst_sram_req), 65'(0));
      check("rst_valid", 65'(bus.fs_to_ds_valid), 65'(0));
    end
    m_pc = RST_PC; m_hold = 1'b0;
    m_infl.delete(); m_ibuf.delete(); env_q.delete();
    @(negedge clk);
    reset = 1'b0;
    drive();
    step();
    repeat (8) cycle();
    check("t1_hs0", 65'(hsat(0)), 65'(32'h1C000000));
    check("t1_hs1", 65'(hsat(1)), 65'(32'h1C000004));
    check("t1_hs2", 65'(hsat(2)), 65'(32'h1C000008));
    check("t1_id0", gotat(0), {1'b0, mem(32'h1C000000), 32'h1C000000});
    check("t1_id1", gotat(1), {1'b0, mem(32'h1C000004), 32'h1C000004});
    check("t1_id2", gotat(2), {1'b0, mem(32'h1C000008), 32'h1C000008});

    quiesce();
    hs_addrs.delete();
    p_aok = 100; p_dok = 0;
    repeat (6) cycle();
    check("t2_hs", 65'(hs_addrs.size()), 65'(2));
    check("t2_req", 65'(last_req), 65'(0));

    redirect(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1C000100, 32'h0, 32'h0);
    got.delete();
    p_dok = 100;
    repeat (10) cycle();
    check("t3_first", gotat(0), {1'b0, mem(32'h1C000100), 32'h1C000100});

    quiesce();
    redirect(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1C000300, 32'h1C008000, 32'h0);
    hs_addrs.delete();
    p_aok = 100;
    repeat (4) cycle();
    check("t4_hs", 65'(hsat(0)), 65'(32'h1C008000));

    quiesce();
    p_aok = 100;
    redirect(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1C000102, 32'h0, 32'h0);
    got.delete(); hs_addrs.delete();
    repeat (8) cycle();
    check("t5_n", 65'(got.size()), 65'(1));
    check("t5_adef", gotat(0), {1'b1, 32'h0, 32'h1C000102});
    check("t5_hs", 65'(hs_addrs.size()), 65'(0));

    p_allow = 0;
    redirect(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1C000200, 32'h0);
    got.delete(); hs_addrs.delete();
    repeat (10) cycle();
    check("t6_hs", 65'(hs_addrs.size()), 65'(4));
    check("t6_held", 65'(got.size()), 65'(0));
    check("t6_valid", 65'(last_valid), 65'(1));
    check("t6_req", 65'(last_req), 65'(0));
    p_allow = 100;
    repeat (12) cycle();
    for (int i = 0; i < 5; i++)
      check("t6_drain", gotat(i), {1'b0, mem(32'h1C000200 + 32'(4 * i)), 32'h1C000200 + 32'(4 * i)});

    for (int chunk = 0; chunk < 30; chunk++) begin
      p_aok   = 30 + int'($urandom_range(70));
      p_dok   = 20 + int'($urandom_range(80));
      p_allow = 10 + int'($urandom_range(90));
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(99) < 4)
          redirect($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(1) == 0,
                   $urandom_range(3) == 0, $urandom_range(4) == 0,
                   rand_target(), rand_target(), rand_target());
        else
          cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
